sprite_priority_scanner: RTL and testbench

Parametrised sprite hit finder for the video pipeline. For one pixel position (H, V) it scans a sprite attribute table and returns the highest-priority sprites covering that pixel, up to MAX_HITS of them, sorted by layer. It also reports the hit count and whether more sprites overlapped than fit. It sits between the VGA position counters and the sprite memory controller, which consumes the sorted hit list.

---
 rtl/sprite_pkg.sv | 23 ++
 rtl/sprite_topk_insert.sv | 72 +++++++
 rtl/sprite_priority_scanner.sv | 149 ++++++++++++++
 tb/tb_sprite_priority_scanner.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/sprite_pkg.sv
// Shared constants, state encoding and helpers for the sprite hit scanner.
// Imported by the scanner top and its insertion sub-block.
package sprite_pkg;

  localparam int N_SPRITES_DEF   = 32;
  localparam int COORD_W_DEF     = 10;
  localparam int LAYER_W_DEF     = 6;
  localparam int SPRITE_SIZE_DEF = 16;
  localparam int MAX_HITS_DEF    = 4;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DONE
  } state_t;

  // All-ones layer of width w marks a disabled sprite.
  function automatic logic [31:0] layer_off(input int w);
    if (w >= 32) return '1;
    return (32'd1 << w) - 32'd1;
  endfunction

endpackage

// File: rtl/sprite_topk_insert.sv
// Combinational insertion of one {idx, layer} candidate into a sorted list.
// Slot 0 is best; larger layer wins, ties go to the lower index.
module sprite_topk_insert
  import sprite_pkg::*;
#(
  parameter int MAX_HITS = MAX_HITS_DEF,
  parameter int IDX_W    = 5,
  parameter int LAYER_W  = LAYER_W_DEF,
  parameter int CNT_W    = $clog2(MAX_HITS + 1)
) (
  input  logic [MAX_HITS*IDX_W-1:0]   ids_in,
  input  logic [MAX_HITS*LAYER_W-1:0] layers_in,
  input  logic [CNT_W-1:0]            count_in,
  input  logic                        cand_valid,
  input  logic [IDX_W-1:0]            cand_idx,
  input  logic [LAYER_W-1:0]          cand_layer,
  output logic [MAX_HITS*IDX_W-1:0]   ids_out,
  output logic [MAX_HITS*LAYER_W-1:0] layers_out,
  output logic [CNT_W-1:0]            count_out,
  output logic                        ovf
);

  localparam logic [CNT_W-1:0] FULL = CNT_W'(MAX_HITS);

  logic [MAX_HITS:0]                  beat;
  logic [(MAX_HITS+1)*IDX_W-1:0]      ids_ext;
  logic [(MAX_HITS+1)*LAYER_W-1:0]    lay_ext;
  logic [IDX_W-1:0]                   s_idx;
  logic [LAYER_W-1:0]                 s_lay;
  logic                               s_ok;

  // beat[k+1]: candidate outranks slot k; beat[0] is a zero guard.
  always_comb begin
    beat = '0;
    s_idx = '0;
    s_lay = '0;
    s_ok = 1'b0;
    for (int k = 0; k < MAX_HITS; k++) begin
      s_idx = ids_in[k*IDX_W +: IDX_W];
      s_lay = layers_in[k*LAYER_W +: LAYER_W];
      s_ok = CNT_W'(k) < count_in;
      beat[k+1] = cand_valid &&
                  (!s_ok || cand_layer > s_lay ||
                   (cand_layer == s_lay && cand_idx < s_idx));
    end
  end

  assign ids_ext = {ids_in, {IDX_W{1'b1}}};
  assign lay_ext = {layers_in, {LAYER_W{1'b1}}};

  always_comb begin
    ids_out = ids_in;
    layers_out = layers_in;
    for (int k = 0; k < MAX_HITS; k++) begin
      if (beat[k+1] && !beat[k]) begin
        ids_out[k*IDX_W +: IDX_W] = cand_idx;
        layers_out[k*LAYER_W +: LAYER_W] = cand_layer;
      end else if (beat[k+1]) begin
        ids_out[k*IDX_W +: IDX_W] = ids_ext[k*IDX_W +: IDX_W];
        layers_out[k*LAYER_W +: LAYER_W] = lay_ext[k*LAYER_W +: LAYER_W];
      end
    end
  end

  always_comb begin
    ovf = cand_valid && (count_in == FULL);
    count_out = count_in;
    if (cand_valid && count_in != FULL)
      count_out = count_in + CNT_W'(1);
  end

endmodule

// File: rtl/sprite_priority_scanner.sv
// Scans the sprite attribute table for one pixel, one entry per cycle,
// and keeps the MAX_HITS best covering sprites sorted by layer.
module sprite_priority_scanner
  import sprite_pkg::*;
#(
  parameter int N_SPRITES   = N_SPRITES_DEF,
  parameter int COORD_W     = COORD_W_DEF,
  parameter int LAYER_W     = LAYER_W_DEF,
  parameter int SPRITE_SIZE = SPRITE_SIZE_DEF,
  parameter int MAX_HITS    = MAX_HITS_DEF,
  localparam int IDX_W      = $clog2(N_SPRITES),
  localparam int CNT_W      = $clog2(MAX_HITS + 1)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        wr_en,
  input  logic [IDX_W-1:0]            wr_idx,
  input  logic [COORD_W-1:0]          wr_x,
  input  logic [COORD_W-1:0]          wr_y,
  input  logic [LAYER_W-1:0]          wr_layer,
  input  logic                        start,
  input  logic [COORD_W-1:0]          h_pos,
  input  logic [COORD_W-1:0]          v_pos,
  output logic                        busy,
  output logic                        done,
  output logic [MAX_HITS*IDX_W-1:0]   hit_ids,
  output logic [MAX_HITS*LAYER_W-1:0] hit_layers,
  output logic [CNT_W-1:0]            hit_count,
  output logic                        overflow
);

  localparam logic [LAYER_W-1:0] LAYER_OFF = LAYER_W'(layer_off(LAYER_W));
  localparam logic [COORD_W:0]   SZ        = (COORD_W+1)'(SPRITE_SIZE);
  localparam logic [IDX_W-1:0]   LAST      = IDX_W'(N_SPRITES - 1);

  logic [COORD_W-1:0] tab_x [N_SPRITES];
  logic [COORD_W-1:0] tab_y [N_SPRITES];
  logic [LAYER_W-1:0] tab_l [N_SPRITES];

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   scan_idx;
  logic [COORD_W-1:0] h_q, v_q;
  logic               accept;

  logic [COORD_W-1:0] cur_x, cur_y;
  logic [LAYER_W-1:0] cur_l;
  logic [COORD_W:0]   hx, vy, ax, ay;
  logic               cand_valid;

  logic [MAX_HITS*IDX_W-1:0]   ins_ids;
  logic [MAX_HITS*LAYER_W-1:0] ins_layers;
  logic [CNT_W-1:0]            ins_count;
  logic                        ins_ovf;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < N_SPRITES; i++) begin
        tab_x[i] <= '0;
        tab_y[i] <= '0;
        tab_l[i] <= LAYER_OFF;
      end
    end else if (wr_en) begin
      tab_x[wr_idx] <= wr_x;
      tab_y[wr_idx] <= wr_y;
      tab_l[wr_idx] <= wr_layer;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    accept = 1'b0;
    unique case (state_q)
      IDLE: begin
        accept = start;
        if (start) state_d = SCAN;
      end
      SCAN: if (scan_idx == LAST) state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign busy = state_q != IDLE;
  assign done = state_q == DONE;

  // Read is combinational, so a same-cycle write is seen next scan.
  assign cur_x = tab_x[scan_idx];
  assign cur_y = tab_y[scan_idx];
  assign cur_l = tab_l[scan_idx];

  assign hx = {1'b0, h_q};
  assign vy = {1'b0, v_q};
  assign ax = {1'b0, cur_x};
  assign ay = {1'b0, cur_y};

  assign cand_valid = (state_q == SCAN) && (cur_l != LAYER_OFF) &&
                      (ax <= hx) && (hx < ax + SZ) &&
                      (ay <= vy) && (vy < ay + SZ);

  sprite_topk_insert #(
    .MAX_HITS (MAX_HITS),
    .IDX_W    (IDX_W),
    .LAYER_W  (LAYER_W),
    .CNT_W    (CNT_W)
  ) u_ins (
    .ids_in     (hit_ids),
    .layers_in  (hit_layers),
    .count_in   (hit_count),
    .cand_valid (cand_valid),
    .cand_idx   (scan_idx),
    .cand_layer (cur_l),
    .ids_out    (ins_ids),
    .layers_out (ins_layers),
    .count_out  (ins_count),
    .ovf        (ins_ovf)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scan_idx   <= '0;
      h_q        <= '0;
      v_q        <= '0;
      hit_ids    <= '1;
      hit_layers <= '1;
      hit_count  <= '0;
      overflow   <= 1'b0;
    end else if (accept) begin
      scan_idx   <= '0;
      h_q        <= h_pos;
      v_q        <= v_pos;
      hit_ids    <= '1;
      hit_layers <= '1;
      hit_count  <= '0;
      overflow   <= 1'b0;
    end else if (state_q == SCAN) begin
      scan_idx   <= scan_idx + IDX_W'(1);
      hit_ids    <= ins_ids;
      hit_layers <= ins_layers;
      hit_count  <= ins_count;
      overflow   <= overflow | ins_ovf;
    end
  end

endmodule

// File: tb/tb_sprite_priority_scanner.sv
// Directed bench for sprite_priority_scanner at default parameters.
// Expected values are hand-computed from the scan rules.
module tb_sprite_priority_scanner;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        wr_en = 1'b0;
  logic [4:0]  wr_idx = '0;
  logic [9:0]  wr_x = '0;
  logic [9:0]  wr_y = '0;
  logic [5:0]  wr_layer = '0;
  logic        start = 1'b0;
  logic [9:0]  h_pos = '0;
  logic [9:0]  v_pos = '0;
  logic        busy;
  logic        done;
  logic [19:0] hit_ids;
  logic [23:0] hit_layers;
  logic [2:0]  hit_count;
  logic        overflow;

  int n_pass = 0;
  int n_total = 0;
  int lat;
  int seen;

  sprite_priority_scanner dut (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (wr_en),
    .wr_idx     (wr_idx),
    .wr_x       (wr_x),
    .wr_y       (wr_y),
    .wr_layer   (wr_layer),
    .start      (start),
    .h_pos      (h_pos),
    .v_pos      (v_pos),
    .busy       (busy),
    .done       (done),
    .hit_ids    (hit_ids),
    .hit_layers (hit_layers),
    .hit_count  (hit_count),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic wr(input int idx, input int x, input int y, input int l);
    @(negedge clk);
    wr_en = 1'b1;
    wr_idx = 5'(idx);
    wr_x = 10'(x);
    wr_y = 10'(y);
    wr_layer = 6'(l);
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  // kind 1: second start at cycle ev; kind 2: write entry 5 layer 7.
  task automatic run_scan(input int h, input int v, input int ev,
                          input int kind, output int lat_o);
    @(negedge clk);
    start = 1'b1;
    h_pos = 10'(h);
    v_pos = 10'(v);
    lat_o = 0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (c == 1) start = 1'b0;
      if (c == ev && kind == 1) begin
        start = 1'b1;
        h_pos = 10'd500;
        v_pos = 10'd500;
      end
      if (c == ev && kind == 2) begin
        wr_en = 1'b1;
        wr_idx = 5'd5;
        wr_x = 10'd0;
        wr_y = 10'd0;
        wr_layer = 6'd7;
      end
      if (c == ev + 1) begin
        start = 1'b0;
        wr_en = 1'b0;
      end
      if (done) begin
        lat_o = c;
        break;
      end
    end
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_count", 32'(hit_count), 0);
    check("rst_ovf", 32'(overflow), 0);
    check("rst_ids", 32'(hit_ids), 32'hFFFFF);
    check("rst_layers", 32'(hit_layers), 32'hFFFFFF);
    rst = 1'b1;
    @(negedge clk);

    run_scan(0, 0, 0, 0, lat);
    check("empty_lat", 32'(lat), 33);
    check("empty_count", 32'(hit_count), 0);
    check("empty_ovf", 32'(overflow), 0);
    check("empty_ids", 32'(hit_ids), 32'hFFFFF);

    do_reset();
    wr(3, 100, 50, 5);
    wr(7, 108, 58, 9);
    run_scan(110, 60, 0, 0, lat);
    check("two_id0", 32'(hit_ids[0+:5]), 7);
    check("two_id1", 32'(hit_ids[5+:5]), 3);
    check("two_id2", 32'(hit_ids[10+:5]), 31);
    check("two_lay0", 32'(hit_layers[0+:6]), 9);
    check("two_lay1", 32'(hit_layers[6+:6]), 5);
    check("two_lay2", 32'(hit_layers[12+:6]), 63);
    check("two_count", 32'(hit_count), 2);
    check("two_ovf", 32'(overflow), 0);

    do_reset();
    wr(0, 120, 200, 1);
    wr(1, 120, 200, 4);
    wr(2, 120, 200, 4);
    wr(3, 120, 200, 8);
    wr(4, 120, 200, 2);
    wr(5, 120, 200, 6);
    run_scan(120, 200, 0, 0, lat);
    check("six_ids", 32'(hit_ids), {12'd0, 5'd2, 5'd1, 5'd5, 5'd3});
    check("six_layers", 32'(hit_layers), {8'd0, 6'd4, 6'd4, 6'd6, 6'd8});
    check("six_count", 32'(hit_count), 4);
    check("six_ovf", 32'(overflow), 1);

    do_reset();
    wr(0, 624, 464, 3);
    run_scan(639, 479, 0, 0, lat);
    check("edge_in_cnt", 32'(hit_count), 1);
    check("edge_in_id", 32'(hit_ids[0+:5]), 0);
    run_scan(640, 479, 0, 0, lat);
    check("edge_right_cnt", 32'(hit_count), 0);
    run_scan(623, 479, 0, 0, lat);
    check("edge_left_cnt", 32'(hit_count), 0);
    do_reset();
    wr(1, 1016, 0, 3);
    run_scan(2, 0, 0, 0, lat);
    check("nowrap_miss", 32'(hit_count), 0);
    run_scan(1020, 5, 0, 0, lat);
    check("nowrap_hit", 32'(hit_count), 1);
    check("nowrap_id", 32'(hit_ids[0+:5]), 1);

    do_reset();
    wr(2, 0, 0, 1);
    run_scan(5, 5, 5, 1, lat);
    check("restart_lat", 32'(lat), 33);
    check("restart_count", 32'(hit_count), 1);
    check("restart_busy_done", 32'(busy), 1);
    @(negedge clk);
    check("restart_busy_after", 32'(busy), 0);
    check("restart_done_after", 32'(done), 0);

    @(negedge clk);
    start = 1'b1;
    h_pos = 10'd5;
    v_pos = 10'd5;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    check("mid_busy_before", 32'(busy), 1);
    rst = 1'b0;
    #1;
    check("mid_busy", 32'(busy), 0);
    check("mid_done", 32'(done), 0);
    check("mid_count", 32'(hit_count), 0);
    check("mid_ids", 32'(hit_ids), 32'hFFFFF);
    @(negedge clk);
    rst = 1'b1;
    seen = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (done || busy) seen++;
    end
    check("mid_no_done", 32'(seen), 0);

    do_reset();
    wr(5, 0, 0, 2);
    run_scan(3, 3, 6, 2, lat);
    check("coll_lat", 32'(lat), 33);
    check("coll_old_layer", 32'(hit_layers[0+:6]), 2);
    check("coll_old_id", 32'(hit_ids[0+:5]), 5);
    run_scan(3, 3, 0, 0, lat);
    check("coll_new_layer", 32'(hit_layers[0+:6]), 7);
    check("coll_new_count", 32'(hit_count), 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
